// File: rtl/latency_tdp_ram.sv
// Single-clock true dual-port RAM with per-port write/read latency pipelines and port-A-wins collision rule.
// Optional LATENCY_TDP_RAM_COLLISION_EN adds the registered o_collision pulse output.

// Reset-cleared delay line; each stage only loads data when the stage before it is valid,
// so the last stage holds the most recent valid word.
module latency_tdp_ram_pipe #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

endmodule

module latency_tdp_ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 16,
  parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
  parameter int WR_LATENCYA = 1,
  parameter int RD_LATENCYA = 1,
  parameter int WR_LATENCYB = 1,
  parameter int RD_LATENCYB = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ena,
  input  logic                  i_we_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [DATA_WIDTH-1:0] i_din_a,
  output logic [DATA_WIDTH-1:0] o_dout_a,
  output logic                  o_valid_a,
  input  logic                  i_enb,
  input  logic                  i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [DATA_WIDTH-1:0] i_din_b,
  output logic [DATA_WIDTH-1:0] o_dout_b,
  output logic                  o_valid_b
`ifdef LATENCY_TDP_RAM_COLLISION_EN
  ,
  output logic                  o_collision
`endif
);

  localparam int                PAYLOAD_W   = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if (WR_LATENCYA < 1 || WR_LATENCYA > 8 || RD_LATENCYA < 1 || RD_LATENCYA > 8 ||
      WR_LATENCYB < 1 || WR_LATENCYB > 8 || RD_LATENCYB < 1 || RD_LATENCYB > 8) begin : g_bad_latency
    $error("latency_tdp_ram: every latency parameter must be in 1..8");
  end
  if (MEM_DEPTH < 2) begin : g_bad_depth
    $error("latency_tdp_ram: MEM_DEPTH must be at least 2");
  end

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH_LIMIT;
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic                  wr_req_a, wr_req_b, rd_req_a, rd_req_b;
  logic                  commit_v_a, commit_v_b;
  logic [ADDR_WIDTH-1:0] commit_addr_a, commit_addr_b;
  logic [DATA_WIDTH-1:0] commit_data_a, commit_data_b;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
  logic                  we_a, we_b, collide;

  assign wr_req_a = i_ena & i_we_a;
  assign rd_req_a = i_ena & ~i_we_a;
  assign wr_req_b = i_enb & i_we_b;
  assign rd_req_b = i_enb & ~i_we_b;

  // A latency of one commits straight from the ports; anything longer goes through W-1 stages.
  if (WR_LATENCYA == 1) begin : g_wr_a_direct
    assign commit_v_a    = rst_n & wr_req_a;
    assign commit_addr_a = i_addr_a;
    assign commit_data_a = i_din_a;
  end else begin : g_wr_a_pipe
    logic [PAYLOAD_W-1:0] payload;
    latency_tdp_ram_pipe #(.STAGES(WR_LATENCYA - 1), .WIDTH(PAYLOAD_W)) u_wr_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (wr_req_a),
      .in_data  ({i_addr_a, i_din_a}),
      .out_valid(commit_v_a),
      .out_data (payload)
    );
    assign commit_addr_a = payload[PAYLOAD_W-1:DATA_WIDTH];
    assign commit_data_a = payload[DATA_WIDTH-1:0];
  end

  if (WR_LATENCYB == 1) begin : g_wr_b_direct
    assign commit_v_b    = rst_n & wr_req_b;
    assign commit_addr_b = i_addr_b;
    assign commit_data_b = i_din_b;
  end else begin : g_wr_b_pipe
    logic [PAYLOAD_W-1:0] payload;
    latency_tdp_ram_pipe #(.STAGES(WR_LATENCYB - 1), .WIDTH(PAYLOAD_W)) u_wr_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (wr_req_b),
      .in_data  ({i_addr_b, i_din_b}),
      .out_valid(commit_v_b),
      .out_data (payload)
    );
    assign commit_addr_b = payload[PAYLOAD_W-1:DATA_WIDTH];
    assign commit_data_b = payload[DATA_WIDTH-1:0];
  end

  // Port A wins a same-address commit; out-of-range commits are dropped.
  assign we_a    = commit_v_a & in_range(commit_addr_a);
  assign collide = we_a & commit_v_b & (commit_addr_a == commit_addr_b);
  assign we_b    = commit_v_b & in_range(commit_addr_b) & ~collide;

  always_ff @(posedge clk) begin
    if (we_b) mem[commit_addr_b] <= commit_data_b;
    if (we_a) mem[commit_addr_a] <= commit_data_a;
  end

  // Reads sample the array before this edge's commits land, so read-during-write returns old data.
  assign rd_word_a = in_range(i_addr_a) ? mem[i_addr_a] : '0;
  assign rd_word_b = in_range(i_addr_b) ? mem[i_addr_b] : '0;

  latency_tdp_ram_pipe #(.STAGES(RD_LATENCYA), .WIDTH(DATA_WIDTH)) u_rd_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_req_a),
    .in_data  (rd_word_a),
    .out_valid(o_valid_a),
    .out_data (o_dout_a)
  );

  latency_tdp_ram_pipe #(.STAGES(RD_LATENCYB), .WIDTH(DATA_WIDTH)) u_rd_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_req_b),
    .in_data  (rd_word_b),
    .out_valid(o_valid_b),
    .out_data (o_dout_b)
  );

`ifdef LATENCY_TDP_RAM_COLLISION_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_collision <= 1'b0;
    else        o_collision <= collide;
  end
`endif

endmodule

// File: tb/tb_latency_tdp_ram.sv
// Directed bench: dut x uses unit latencies, dut y uses WR_LATENCYA=4, RD_LATENCYB=3, MEM_DEPTH=12.
// Collision checks are compiled only when LATENCY_TDP_RAM_COLLISION_EN is defined.
module tb_latency_tdp_ram;

  logic clk;
  logic rst_n;

  logic       x_ena, x_we_a, x_enb, x_we_b, x_valid_a, x_valid_b;
  logic [3:0] x_addr_a, x_addr_b;
  logic [7:0] x_din_a, x_din_b, x_dout_a, x_dout_b;
  logic       y_ena, y_we_a, y_enb, y_we_b, y_valid_a, y_valid_b;
  logic [3:0] y_addr_a, y_addr_b;
  logic [7:0] y_din_a, y_din_b, y_dout_a, y_dout_b;
`ifdef LATENCY_TDP_RAM_COLLISION_EN
  logic x_collision, y_collision;
`endif

  int compared   = 0;
  int mismatched = 0;

  latency_tdp_ram dut_x (
    .clk(clk), .rst_n(rst_n),
    .i_ena(x_ena), .i_we_a(x_we_a), .i_addr_a(x_addr_a), .i_din_a(x_din_a),
    .o_dout_a(x_dout_a), .o_valid_a(x_valid_a),
    .i_enb(x_enb), .i_we_b(x_we_b), .i_addr_b(x_addr_b), .i_din_b(x_din_b),
    .o_dout_b(x_dout_b), .o_valid_b(x_valid_b)
`ifdef LATENCY_TDP_RAM_COLLISION_EN
    , .o_collision(x_collision)
`endif
  );

  latency_tdp_ram #(.MEM_DEPTH(12), .WR_LATENCYA(4), .RD_LATENCYB(3)) dut_y (
    .clk(clk), .rst_n(rst_n),
    .i_ena(y_ena), .i_we_a(y_we_a), .i_addr_a(y_addr_a), .i_din_a(y_din_a),
    .o_dout_a(y_dout_a), .o_valid_a(y_valid_a),
    .i_enb(y_enb), .i_we_b(y_we_b), .i_addr_b(y_addr_b), .i_din_b(y_din_b),
    .o_dout_b(y_dout_b), .o_valid_b(y_valid_b)
`ifdef LATENCY_TDP_RAM_COLLISION_EN
    , .o_collision(y_collision)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of requests to dut x (sel_y=0) or dut y (sel_y=1), idles the other,
  // then returns 1ns after the edge that sampled them.
  task automatic apply_stimulus(input bit sel_y,
                                input logic ena, input logic we_a, input logic [3:0] addr_a, input logic [7:0] din_a,
                                input logic enb, input logic we_b, input logic [3:0] addr_b, input logic [7:0] din_b);
    x_ena = !sel_y & ena;  x_we_a = we_a; x_addr_a = addr_a; x_din_a = din_a;
    x_enb = !sel_y & enb;  x_we_b = we_b; x_addr_b = addr_b; x_din_b = din_b;
    y_ena = sel_y & ena;   y_we_a = we_a; y_addr_a = addr_a; y_din_a = din_a;
    y_enb = sel_y & enb;   y_we_b = we_b; y_addr_b = addr_b; y_din_b = din_b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
  endtask

  logic [7:0] seq_data [3];
  logic [3:0] chk_addr [5];
  logic [7:0] chk_data [5];

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    check_output("rst_x_dout_a", x_dout_a, 8'h00);
    check_output("rst_x_valid_a", x_valid_a, 1'b0);
    check_output("rst_y_dout_b", y_dout_b, 8'h00);
    check_output("rst_y_valid_b", y_valid_b, 1'b0);
`ifdef LATENCY_TDP_RAM_COLLISION_EN
    check_output("rst_x_collision", x_collision, 1'b0);
`endif
    rst_n = 1'b1;
    idle();

    // Unit latency write then read, with dout held after the strobe drops.
    apply_stimulus(0, 1, 1, 4'd3, 8'h5A, 0, 0, 4'd0, 8'h00);
    check_output("x_no_valid_on_write", x_valid_a, 1'b0);
    apply_stimulus(0, 1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    check_output("x_rd3_data", x_dout_a, 8'h5A);
    check_output("x_rd3_valid", x_valid_a, 1'b1);
    idle();
    check_output("x_rd3_valid_drop", x_valid_a, 1'b0);
    check_output("x_rd3_hold", x_dout_a, 8'h5A);

    // Read-during-write on the other port returns the old word.
    apply_stimulus(0, 1, 1, 4'd3, 8'h77, 1, 0, 4'd3, 8'h00);
    check_output("x_rdw_old", x_dout_b, 8'h5A);
    check_output("x_rdw_valid", x_valid_b, 1'b1);
    apply_stimulus(0, 0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00);
    check_output("x_rdw_new", x_dout_b, 8'h77);

    // Same-address collision: A wins; different addresses both land.
    apply_stimulus(0, 1, 1, 4'd7, 8'hAA, 1, 1, 4'd7, 8'hBB);
`ifdef LATENCY_TDP_RAM_COLLISION_EN
    check_output("x_collision_pulse", x_collision, 1'b1);
`endif
    apply_stimulus(0, 1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00);
    check_output("x_coll_rd_a", x_dout_a, 8'hAA);
    check_output("x_coll_rd_b", x_dout_b, 8'hAA);
`ifdef LATENCY_TDP_RAM_COLLISION_EN
    check_output("x_collision_drop", x_collision, 1'b0);
`endif
    apply_stimulus(0, 1, 1, 4'd8, 8'h01, 1, 1, 4'd9, 8'h02);
`ifdef LATENCY_TDP_RAM_COLLISION_EN
    check_output("x_no_collision", x_collision, 1'b0);
`endif
    apply_stimulus(0, 1, 0, 4'd8, 8'h00, 1, 0, 4'd9, 8'h00);
    check_output("x_diff_rd_a", x_dout_a, 8'h01);
    check_output("x_diff_rd_b", x_dout_b, 8'h02);

    // dut y: port A write latency 4 against port B reads of latency 3.
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 1, 4'd2, 8'h22);
    apply_stimulus(1, 1, 1, 4'd2, 8'h11, 0, 0, 4'd0, 8'h00);
    idle();
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 0, 4'd2, 8'h00);
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 0, 4'd2, 8'h00);
    check_output("y_wlat_no_valid_yet", y_valid_b, 1'b0);
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 0, 4'd2, 8'h00);
    check_output("y_wlat_rd_e2_old", y_dout_b, 8'h22);
    check_output("y_wlat_rd_e2_valid", y_valid_b, 1'b1);
    idle();
    check_output("y_wlat_rd_e3_old", y_dout_b, 8'h22);
    idle();
    check_output("y_wlat_rd_e4_new", y_dout_b, 8'h11);
    idle();
    check_output("y_wlat_valid_drop", y_valid_b, 1'b0);
    check_output("y_wlat_hold", y_dout_b, 8'h11);
    apply_stimulus(1, 1, 0, 4'd2, 8'h00, 0, 0, 4'd0, 8'h00);
    check_output("y_rd_a_committed", y_dout_a, 8'h11);

    // Three back-to-back port-B reads produce three consecutive strobes in order.
    seq_data[0] = 8'h55; seq_data[1] = 8'h66; seq_data[2] = 8'h77;
    for (int i = 0; i < 3; i++)
      apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 1, 4'(5 + i), seq_data[i]);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 0, 4'(5 + k), 8'h00);
      else       idle();
      check_output($sformatf("y_burst_valid_%0d", k), y_valid_b, (k >= 2 && k <= 4) ? 1'b1 : 1'b0);
      if (k >= 2 && k <= 4)
        check_output($sformatf("y_burst_data_%0d", k), y_dout_b, seq_data[k-2]);
    end

    // Reset while a port-A write and a port-B read are in flight.
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 1, 4'd9, 8'h99);
    apply_stimulus(1, 1, 1, 4'd9, 8'hEE, 1, 0, 4'd9, 8'h00);
    idle();
    rst_n = 1'b0;
    #1;
    check_output("midrst_y_dout_a", y_dout_a, 8'h00);
    check_output("midrst_y_dout_b", y_dout_b, 8'h00);
    check_output("midrst_y_valid_b", y_valid_b, 1'b0);
    check_output("midrst_x_dout_a", x_dout_a, 8'h00);
    idle();
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    check_output("postrst_no_valid_b", y_valid_b, 1'b0);
    apply_stimulus(1, 1, 0, 4'd9, 8'h00, 0, 0, 4'd0, 8'h00);
    check_output("postrst_keeps_prior", y_dout_a, 8'h99);
    check_output("postrst_no_valid_b2", y_valid_b, 1'b0);

    // Out-of-range writes are dropped and out-of-range reads return zero with a strobe.
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 1, 4'd0, 8'hA0);
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 1, 4'd1, 8'h01);
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 1, 4'd11, 8'hB1);
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 1, 4'd12, 8'hFF);
    apply_stimulus(1, 0, 0, 4'd0, 8'h00, 1, 1, 4'd13, 8'hFF);
    chk_addr[0] = 4'd0;  chk_data[0] = 8'hA0;
    chk_addr[1] = 4'd1;  chk_data[1] = 8'h01;
    chk_addr[2] = 4'd11; chk_data[2] = 8'hB1;
    chk_addr[3] = 4'd12; chk_data[3] = 8'h00;
    chk_addr[4] = 4'd13; chk_data[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 1, 0, chk_addr[i], 8'h00, 0, 0, 4'd0, 8'h00);
      check_output($sformatf("y_range_data_%0d", chk_addr[i]), y_dout_a, chk_data[i]);
      check_output($sformatf("y_range_valid_%0d", chk_addr[i]), y_valid_a, 1'b1);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
